// File: rtl/irq_ctrl.sv
// irq_ctrl: Wishbone-slave interrupt controller with synchronised sources,
// edge/level mode, fixed lowest-index priority and claim/complete.
module irq_ctrl #(
  parameter int NUM_SRC    = 8,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH-1:0] wb_addr,
  input  logic [31:0]           wb_dat_i,
  output logic [31:0]           wb_dat_o,
  input  logic                  wb_we,
  input  logic [3:0]            wb_sel,
  input  logic                  wb_stb,
  output logic                  wb_ack,
  input  logic [NUM_SRC-1:0]    irq_src,
  output logic                  irq_out
);

  typedef enum logic {
    IDLE,
    BUSY
  } state_t;

  localparam logic [5:0] A_PEND  = 6'h00;
  localparam logic [5:0] A_EN    = 6'h01;
  localparam logic [5:0] A_MODE  = 6'h02;
  localparam logic [5:0] A_CLAIM = 6'h03;
  localparam logic [5:0] A_CMPL  = 6'h04;
  localparam logic [5:0] A_RAW   = 6'h05;

  state_t state;

  logic [NUM_SRC-1:0] s1;
  logic [NUM_SRC-1:0] s2;
  logic [NUM_SRC-1:0] s3;
  logic [NUM_SRC-1:0] edge_pend;
  logic [NUM_SRC-1:0] enable;
  logic [NUM_SRC-1:0] mode;
  logic [NUM_SRC-1:0] pending;
  logic [NUM_SRC-1:0] active;
  logic [NUM_SRC-1:0] edge_set;
  logic [NUM_SRC-1:0] w1c;
  logic [NUM_SRC-1:0] first;
  logic [NUM_SRC-1:0] claim_clr;
  logic [NUM_SRC-1:0] wdat;

  logic [4:0]  cur_id;
  logic [4:0]  claim_id;
  logic [5:0]  reg_idx;
  logic [31:0] rdata;

  logic acc;
  logic rd;
  logic wr;
  logic hit_pend;
  logic hit_en;
  logic hit_mode;
  logic hit_claim;
  logic hit_cmpl;
  logic hit_raw;
  logic claim_go;
  logic cmpl_go;
  logic unused_ok;

  assign unused_ok = ^{wb_sel, wb_addr, wb_dat_i};

  assign acc     = wb_stb && !wb_ack;
  assign rd      = acc && !wb_we;
  assign wr      = acc && wb_we;
  assign reg_idx = wb_addr[7:2];
  assign wdat    = wb_dat_i[NUM_SRC-1:0];

  assign hit_pend  = (reg_idx == A_PEND);
  assign hit_en    = (reg_idx == A_EN);
  assign hit_mode  = (reg_idx == A_MODE);
  assign hit_claim = (reg_idx == A_CLAIM);
  assign hit_cmpl  = (reg_idx == A_CMPL);
  assign hit_raw   = (reg_idx == A_RAW);

  // Level bits follow the synchronised line; edge bits come from the latch.
  assign pending  = (mode & edge_pend) | (~mode & s2);
  assign active   = pending & enable;
  assign edge_set = mode & s2 & ~s3;

  always_comb begin
    claim_id = '0;
    first    = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (active[i]) begin
        claim_id = 5'(i + 1);
        first    = '0;
        first[i] = 1'b1;
      end
    end
  end

  assign claim_go  = rd && hit_claim
                  && (state == IDLE)
                  && (claim_id != '0);
  assign cmpl_go   = wr && hit_cmpl
                  && (state == BUSY)
                  && (wb_dat_i[4:0] == cur_id);
  assign claim_clr = claim_go ? (first & mode) : '0;
  assign w1c       = (wr && hit_pend) ? (wdat & mode) : '0;

  always_comb begin
    rdata = '0;
    unique case (1'b1)
      hit_pend:  rdata = 32'(pending);
      hit_en:    rdata = 32'(enable);
      hit_mode:  rdata = 32'(mode);
      hit_claim: rdata = (state == IDLE) ? 32'(claim_id) : '0;
      hit_raw:   rdata = 32'(s2);
      default:   rdata = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= '0;
      s2 <= '0;
      s3 <= '0;
    end else begin
      s1 <= irq_src;
      s2 <= s1;
      s3 <= s2;
    end
  end

  // Set beats clear; leaving edge mode drops any stale latch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      edge_pend <= '0;
    end else begin
      edge_pend <= mode
                 & ((edge_pend & ~w1c & ~claim_clr)
                 | edge_set);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      enable <= '0;
      mode   <= '0;
    end else if (wr) begin
      if (hit_en) enable <= wdat;
      if (hit_mode) mode <= wdat;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_ack   <= 1'b0;
      wb_dat_o <= '0;
    end else begin
      wb_ack <= acc;
      if (acc) wb_dat_o <= wb_we ? '0 : rdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cur_id  <= '0;
      irq_out <= 1'b0;
    end else begin
      irq_out <= (|active) && (state == IDLE);
      unique case (state)
        IDLE: begin
          if (claim_go) begin
            state  <= BUSY;
            cur_id <= claim_id;
          end
        end
        BUSY: begin
          if (cmpl_go) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
